// File: rtl/cam_sync_ctrl_pkg.sv
// Shared constants and types for the camera sync controller and sync generator.
package cam_sync_ctrl_pkg;

  typedef enum logic [1:0] {StInt, StAcq, StLock, StHold} lock_state_e;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrExp    = 2'd1;
  localparam logic [1:0] AddrCommit = 2'd2;
  localparam logic [1:0] AddrRsvd   = 2'd3;

  // Frame geometry shared with the sync generator.
  localparam int unsigned LineCnt    = 1028;
  localparam int unsigned LineLenFr0 = 1064;
  localparam int unsigned LineLenFr1 = 532;
  localparam int unsigned LineLenFr2 = 266;
  localparam int unsigned LineLenFr3 = 133;

  localparam int unsigned PeriodFr0 = LineLenFr0 * LineCnt;  // 1093792
  localparam int unsigned PeriodFr1 = LineLenFr1 * LineCnt;  // 546896
  localparam int unsigned PeriodFr2 = LineLenFr2 * LineCnt;  // 273448
  localparam int unsigned PeriodFr3 = LineLenFr3 * LineCnt;  // 136724

  localparam int unsigned PeriodW = 21;

  function automatic int unsigned line_len(input logic [1:0] fr);
    case (fr)
      2'd0:    return LineLenFr0;
      2'd1:    return LineLenFr1;
      2'd2:    return LineLenFr2;
      default: return LineLenFr3;
    endcase
  endfunction

endpackage

// File: rtl/cam_sync_ctrl_esyn_period_mon.sv
// External sync period monitor: free-running period counter, tolerance window and timeout.
module esyn_period_mon #(
  parameter int unsigned TOL = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        esyn,
  input  logic        clr,
  input  logic [20:0] nom,
  output logic        in_tol,
  output logic        timeout
);

  logic [20:0] cnt_q, cnt_d;
  logic [21:0] period, lo, hi;

  // Counter holds cycles since the last esyn, so the measured period is cnt + 1.
  assign period  = {1'b0, cnt_q} + 22'd1;
  assign lo      = {1'b0, nom} - 22'(TOL);
  assign hi      = {1'b0, nom} + 22'(TOL);
  assign in_tol  = (period >= lo) && (period <= hi);
  assign timeout = {1'b0, cnt_q} > hi;

  // Restart on every esyn or on request, otherwise count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (esyn || clr) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 21'd1;
    end
  end

  // Period counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cam_sync_ctrl.sv
// Sync-source controller: shadowed host config applied on frame boundaries, external sync lock.
module cam_sync_ctrl
  import cam_sync_ctrl_pkg::*;
#(
  parameter int unsigned TOL      = 64,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MISS_MAX = 3,
  parameter int unsigned IEXP_MIN = 2,
  parameter int unsigned LINES    = LineCnt
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        tv,
  input  logic        esyn,
  output logic [1:0]  fr,
  output logic [10:0] iexp,
  output logic        inv,
  output logic        midsyn,
  output logic        extsyn,
  output logic        cfg_pend,
  output logic        cfg_done,
  output logic        locked,
  output logic        lost
);

  logic [1:0]  sh_fr_q, fr_q;
  logic [10:0] sh_iexp_q, iexp_q, iexp_wr;
  logic        sh_inv_q, inv_q, sh_mid_q, mid_q, sh_ext_q, ext_q;
  logic        pend_q, done_q, lost_q, lost_d;
  logic        apply, commit_wr, fr_chg;
  logic        started_q, started_d, clr, in_tol, timeout;
  logic [7:0]  good_q, good_d, miss_q, miss_d;
  logic [20:0] nom;
  lock_state_e state_q, state_d;
  logic        unused_wr_data;

  assign unused_wr_data = ^wr_data[15:11];
  assign iexp_wr   = (wr_data[10:0] < 11'(IEXP_MIN)) ? 11'(IEXP_MIN) : wr_data[10:0];
  assign commit_wr = wr_en && (wr_addr == AddrCommit);
  // Only a request already pending when tv arrives is applied.
  assign apply     = tv && pend_q;
  assign fr_chg    = apply && (sh_fr_q != fr_q);
  assign nom       = 21'(line_len(fr_q) * LINES);

  // Shadow registers, atomic commit into the active set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_fr_q <= '0; sh_inv_q <= 1'b0; sh_mid_q <= 1'b0; sh_ext_q <= 1'b0;
      sh_iexp_q <= 11'(IEXP_MIN);
      fr_q <= '0; inv_q <= 1'b0; mid_q <= 1'b0; ext_q <= 1'b0;
      iexp_q <= 11'(IEXP_MIN);
      pend_q <= 1'b0; done_q <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_addr)
          AddrCtrl: begin
            sh_fr_q  <= wr_data[1:0];
            sh_inv_q <= wr_data[2];
            sh_mid_q <= wr_data[3];
            sh_ext_q <= wr_data[4];
          end
          AddrExp:  sh_iexp_q <= iexp_wr;
          AddrRsvd: ;
          default:  ;
        endcase
      end
      if (apply) begin
        fr_q <= sh_fr_q; inv_q <= sh_inv_q; mid_q <= sh_mid_q; ext_q <= sh_ext_q;
        iexp_q <= sh_iexp_q;
      end
      done_q <= apply;
      if (commit_wr)  pend_q <= 1'b1;
      else if (apply) pend_q <= 1'b0;
    end
  end

  esyn_period_mon #(
    .TOL(TOL)
  ) u_mon (
    .clk    (clk),
    .rst_n  (rst_n),
    .esyn   (esyn),
    .clr    (clr),
    .nom    (nom),
    .in_tol (in_tol),
    .timeout(timeout)
  );

  // Lock FSM next state: ext_req off wins, then rate change, then normal tracking.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    miss_d    = miss_q;
    started_d = started_q;
    clr       = 1'b0;
    lost_d    = 1'b0;
    if (!ext_q) begin
      state_d = StInt; good_d = '0; miss_d = '0; started_d = 1'b0;
    end else if (fr_chg) begin
      state_d = StAcq; good_d = '0; miss_d = '0; started_d = 1'b0; clr = 1'b1;
    end else begin
      unique case (state_q)
        StInt: begin
          state_d = StAcq; good_d = '0; miss_d = '0; started_d = 1'b0; clr = 1'b1;
        end
        StAcq: begin
          if (esyn) begin
            if (!started_q) begin
              started_d = 1'b1;
            end else if (in_tol) begin
              if (good_q + 8'd1 >= 8'(LOCK_CNT)) begin
                state_d = StLock; good_d = '0;
              end else begin
                good_d = good_q + 8'd1;
              end
            end else begin
              good_d = '0;
            end
          end
        end
        StLock: begin
          if (esyn) begin
            // The offending esyn already restarted the counter, so it starts measurement.
            if (!in_tol) begin
              state_d = StAcq; good_d = '0; started_d = 1'b1;
            end
          end else if (timeout) begin
            state_d = StHold; miss_d = 8'd1; clr = 1'b1;
          end
        end
        StHold: begin
          if (esyn) begin
            if (in_tol) begin
              state_d = StLock; miss_d = '0;
            end else begin
              state_d = StAcq; good_d = '0; started_d = 1'b1;
            end
          end else if (timeout) begin
            if (miss_q + 8'd1 >= 8'(MISS_MAX)) begin
              state_d = StInt; miss_d = '0; lost_d = 1'b1;
            end else begin
              miss_d = miss_q + 8'd1; clr = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StInt; good_q <= '0; miss_q <= '0; started_q <= 1'b0; lost_q <= 1'b0;
    end else begin
      state_q <= state_d; good_q <= good_d; miss_q <= miss_d; started_q <= started_d;
      lost_q  <= lost_d;
    end
  end

  assign fr       = fr_q;
  assign iexp     = iexp_q;
  assign inv      = inv_q;
  assign midsyn   = mid_q;
  assign cfg_pend = pend_q;
  assign cfg_done = done_q;
  assign lost     = lost_q;
  assign locked   = (state_q == StLock);
  assign extsyn   = (state_q == StLock) || (state_q == StHold);

endmodule

// File: tb/tb_cam_sync_ctrl.sv
// Directed/randomized bench for cam_sync_ctrl with a short frame (8 lines) to keep runs small.
module tb_cam_sync_ctrl;

  localparam int TOL = 64, LOCK_CNT = 4, MISS_MAX = 3, IEXP_MIN = 2, LINES = 8;

  logic        clk, rst_n, wr_en, tv, esyn;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  fr;
  logic [10:0] iexp;
  logic        inv, midsyn, extsyn, cfg_pend, cfg_done, locked, lost;

  cam_sync_ctrl #(
    .TOL(TOL), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .IEXP_MIN(IEXP_MIN), .LINES(LINES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tv(tv), .esyn(esyn), .fr(fr), .iexp(iexp), .inv(inv), .midsyn(midsyn),
    .extsyn(extsyn), .cfg_pend(cfg_pend), .cfg_done(cfg_done), .locked(locked), .lost(lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model of the register file: shadow set, active set, pending flag.
  logic [1:0]  m_sh_fr, m_fr;
  logic [10:0] m_sh_iexp, m_iexp;
  logic        m_sh_inv, m_inv, m_sh_mid, m_mid, m_sh_ext, m_ext, m_pend;

  function automatic int nominal(input logic [1:0] f);
    int len;
    case (f)
      2'd0:    len = 1064;
      2'd1:    len = 532;
      2'd2:    len = 266;
      default: len = 133;
    endcase
    return len * LINES;
  endfunction

  task automatic model_reset();
    m_sh_fr = 0; m_sh_inv = 0; m_sh_mid = 0; m_sh_ext = 0; m_sh_iexp = 11'(IEXP_MIN);
    m_fr = 0; m_inv = 0; m_mid = 0; m_ext = 0; m_iexp = 11'(IEXP_MIN); m_pend = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic check_cfg(input string tag);
    chk({tag, ".fr"}, 32'(fr), 32'(m_fr));
    chk({tag, ".iexp"}, 32'(iexp), 32'(m_iexp));
    chk({tag, ".inv"}, 32'(inv), 32'(m_inv));
    chk({tag, ".midsyn"}, 32'(midsyn), 32'(m_mid));
    chk({tag, ".cfg_pend"}, 32'(cfg_pend), 32'(m_pend));
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick(1);
    wr_en = 1'b0;
    case (a)
      2'd0: begin m_sh_fr = d[1:0]; m_sh_inv = d[2]; m_sh_mid = d[3]; m_sh_ext = d[4]; end
      2'd1: m_sh_iexp = (int'(d[10:0]) < IEXP_MIN) ? 11'(IEXP_MIN) : d[10:0];
      2'd2: m_pend = 1'b1;
      default: ;
    endcase
  endtask

  task automatic tv_pulse(input string tag);
    logic exp_done;
    tv = 1'b1;
    tick(1);
    tv = 1'b0;
    exp_done = m_pend;
    if (m_pend) begin
      m_fr = m_sh_fr; m_inv = m_sh_inv; m_mid = m_sh_mid; m_ext = m_sh_ext;
      m_iexp = m_sh_iexp; m_pend = 1'b0;
    end
    chk({tag, ".cfg_done"}, 32'(cfg_done), 32'(exp_done));
    check_cfg(tag);
  endtask

  task automatic pulse();
    esyn = 1'b1;
    tick(1);
    esyn = 1'b0;
  endtask

  // Feed LOCK_CNT in-tolerance periods (optionally after an unjudged start pulse).
  task automatic lock_seq(input int nom, input bit need_start);
    int good = 0;
    int p;
    if (need_start) begin
      pulse();
      chk("acq_start.locked", 32'(locked), 0);
    end
    for (int i = 1; i <= LOCK_CNT; i++) begin
      if (i == 1)      p = nom - TOL;
      else if (i == 2) p = nom + TOL;
      else             p = nom - TOL + int'($urandom_range(2 * TOL));
      tick(p - 1);
      pulse();
      good++;
      chk("acq.locked", 32'(locked), 32'(good >= LOCK_CNT));
      chk("acq.extsyn", 32'(extsyn), 32'(good >= LOCK_CNT));
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int nom3, to3;
    rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; tv = 0; esyn = 0;
    model_reset();
    tick(2);
    check_cfg("reset");
    chk("reset.extsyn", 32'(extsyn), 0);
    chk("reset.cfg_done", 32'(cfg_done), 0);
    chk("reset.locked", 32'(locked), 0);
    chk("reset.lost", 32'(lost), 0);
    rst_n = 1;
    tick(1);

    // Clamped exposure commit.
    wr(2'd1, 16'h0001);
    wr(2'd2, 16'h0000);
    tv_pulse("clamp");
    tick(1);
    chk("clamp.done_once", 32'(cfg_done), 0);

    // Commit waits for tv.
    wr(2'd0, 16'h0005);
    wr(2'd2, 16'h0000);
    tick(1000);
    check_cfg("wait_tv");
    tv_pulse("apply_tv");

    // Commit written on the same cycle as tv is deferred to the next tv.
    wr(2'd0, 16'h000A);
    wr_en = 1; wr_addr = 2'd2; wr_data = 0; tv = 1;
    tick(1);
    wr_en = 0; tv = 0; m_pend = 1'b1;
    chk("same_cyc.cfg_done", 32'(cfg_done), 0);
    check_cfg("same_cyc");
    tick(3);
    tv_pulse("same_cyc_next");

    // Acquire at fr=3.
    nom3 = nominal(2'd3);
    to3  = nom3 + TOL + 1;
    wr(2'd0, 16'h0013);
    wr(2'd2, 16'h0000);
    tv_pulse("ext_on");
    tick(2);
    lock_seq(nom3, 1'b1);

    // Lose one pulse, recover from HOLD with an in-tolerance esyn.
    tick(to3);
    chk("pre_hold.locked", 32'(locked), 1);
    tick(1);
    chk("hold.locked", 32'(locked), 0);
    chk("hold.extsyn", 32'(extsyn), 1);
    tick(nom3 - TOL + int'($urandom_range(2 * TOL)) - 1);
    pulse();
    chk("hold_recover.locked", 32'(locked), 1);

    // Stop esyn: HOLD, then fallback after MISS_MAX timeouts.
    tick(to3);
    chk("pre_hold2.locked", 32'(locked), 1);
    tick(1);
    chk("hold2.extsyn", 32'(extsyn), 1);
    chk("hold2.lost", 32'(lost), 0);
    for (int m = 2; m <= MISS_MAX; m++) begin
      tick(to3);
      chk("hold_wait.extsyn", 32'(extsyn), 1);
      tick(1);
      chk("hold_to.lost", 32'(lost), 32'(m == MISS_MAX));
      chk("hold_to.extsyn", 32'(extsyn), 32'(m < MISS_MAX));
    end
    tick(1);
    chk("lost_once", 32'(lost), 0);

    // Relock, then one period of nom+TOL+1 drops to ACQ.
    lock_seq(nom3, 1'b1);
    tick(nom3 + TOL + 1 - 1);
    pulse();
    chk("bad_period.locked", 32'(locked), 0);
    chk("bad_period.extsyn", 32'(extsyn), 0);
    lock_seq(nom3, 1'b0);

    // Rate change while locked forces reacquisition on the commit edge.
    wr(2'd0, 16'h0012);
    wr(2'd2, 16'h0000);
    tv_pulse("fr_chg");
    chk("fr_chg.locked", 32'(locked), 0);
    chk("fr_chg.extsyn", 32'(extsyn), 0);
    lock_seq(nominal(2'd2), 1'b1);

    // ext_req off: INT one edge after apply, no lost pulse.
    wr(2'd0, 16'h0002);
    wr(2'd2, 16'h0000);
    tv_pulse("ext_off");
    chk("ext_off.apply_edge_locked", 32'(locked), 1);
    tick(1);
    chk("ext_off.locked", 32'(locked), 0);
    chk("ext_off.extsyn", 32'(extsyn), 0);
    chk("ext_off.lost", 32'(lost), 0);

    // Random configs; last write before commit wins, addr3 ignored.
    for (int k = 0; k < 4; k++) begin
      wr(2'd1, 16'($urandom));
      wr(2'd0, 16'($urandom) & 16'hFFEF);
      wr(2'd0, 16'($urandom) & 16'hFFEF);
      wr(2'd3, 16'($urandom));
      wr(2'd1, 16'($urandom_range(0, 3)));
      wr(2'd2, 16'h0000);
      tick(int'($urandom_range(1, 20)));
      tv_pulse("rand");
    end

    // Reset with a pending commit discards it.
    wr(2'd0, 16'h0007);
    wr(2'd1, 16'h0123);
    wr(2'd2, 16'h0000);
    chk("pre_rst.cfg_pend", 32'(cfg_pend), 1);
    rst_n = 0;
    tick(1);
    rst_n = 1;
    model_reset();
    check_cfg("mid_rst");
    chk("mid_rst.cfg_done", 32'(cfg_done), 0);
    tick(1);
    tv_pulse("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cam_sync_ctrl.md
Name: cam_sync_ctrl

Overview:
- Configuration and sync-source controller for the camera line/frame sync generator.
- Host writes go into shadow registers. On a commit request they are applied atomically at the next frame boundary (tv pulse).
- Monitors the external sync pulse stream and asserts extsyn to the generator only after a frequency lock is established. Drops back to internal sync when the external source is lost.

Parameters:
- TOL, 64, allowed deviation in clk cycles of a measured external frame period from nominal.
- LOCK_CNT, 4, consecutive in-tolerance periods required to declare lock.
- MISS_MAX, 3, consecutive missed external pulses tolerated before falling back to internal sync.
- IEXP_MIN, 2, minimum exposure value; smaller writes are clamped up to this.

Ports:
- clk  in  1  system clock, 65.625 MHz
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  host register write strobe, one cycle
- wr_addr  in  2  register address
- wr_data  in  16  write data
- tv  in  1  frame-start pulse from sync generator
- esyn  in  1  one-cycle external sync pulse, already edge-detected
- fr  out  2  frame rate to generator: 00=60, 01=120, 10=240, 11=480 Hz
- iexp  out  11  exposure to generator
- inv  out  1  sync inversion to generator
- midsyn  out  1  mid-exposure sync mode to generator
- extsyn  out  1  use external sync (high in LOCK or HOLD only)
- cfg_pend  out  1  commit requested, not yet applied
- cfg_done  out  1  one-cycle pulse on the cycle the config is applied
- locked  out  1  high in LOCK
- lost  out  1  one-cycle pulse on HOLD->INT fallback

Behaviour:
- Reset values: fr=0, iexp=IEXP_MIN, inv=0, midsyn=0, extsyn=0, cfg_pend=0, cfg_done=0, locked=0, lost=0. Shadow registers take the same values; ext_req=0; FSM=INT; all counters 0.
- Register map:
  - addr0: fr=[1:0], inv=[2], midsyn=[3], ext_req=[4].
  - addr1: iexp=[10:0]; written value below IEXP_MIN is stored as IEXP_MIN.
  - addr2: any write sets cfg_pend.
  - addr3: ignored.
- Shadow writes while cfg_pend=1 are accepted; the latest value at commit wins.
- Commit:
  - On the first cycle with tv=1 and cfg_pend=1, active outputs take the shadow values on the next edge.
  - cfg_pend clears and cfg_done pulses on that same edge.
  - Latency: commit write to apply is at most one frame.
- Commit-write on the same cycle as tv: tv applies nothing new. The commit waits for the next tv.
- Nominal period by active fr: 1093792 / 546896 / 273448 / 136724 cycles (line length 1064/532/266/133 x 1028 lines).
- Period counter: 21 bits. Resets to 0 on each esyn; saturates at its maximum.
- Lock FSM:
  - INT: extsyn=0. Moves to ACQ when active ext_req=1; good-count=0, counter=0.
  - ACQ: on esyn, a period within nominal±TOL increments good-count, otherwise good-count=0. At good-count=LOCK_CNT, go to LOCK. The first esyn after entering ACQ only starts measurement and is not judged.
  - LOCK: extsyn=1, locked=1. esyn in tolerance keeps LOCK. esyn out of tolerance goes to ACQ. Counter exceeding nominal+TOL without esyn goes to HOLD with miss=1 and counter restart.
  - HOLD: extsyn=1, locked=0. In-tolerance esyn goes to LOCK with miss=0. Each further nominal+TOL timeout increments miss. When miss reaches MISS_MAX, go to INT and pulse lost. An out-of-tolerance esyn goes to ACQ.
- Active ext_req=0 in any state forces INT on the next edge; no lost pulse.
- A commit that changes fr while ext_req=1 forces ACQ (relock at the new rate) on the commit edge.
- Reset mid-operation: all state returns to reset values on the next edge. A pending commit is discarded.

Decomposition:
- Shared package:
  - FSM state encoding (INT, ACQ, LOCK, HOLD).
  - Register address constants.
  - Nominal frame-period constants per fr.
  - The line count (1028) and per-fr line lengths, shared with the sync generator.
- Sub-module esyn_period_mon: period counter, tolerance compare and timeout flag.
- Register file and commit logic stay in the top.

Test Plan:
- Reset, then write addr1=0x001, addr2, then pulse tv -> iexp=2 (clamped), cfg_done pulses once, cfg_pend=0.
- Write addr0=0x0005, commit, no tv for 1000 cycles -> fr stays 0, cfg_pend=1; on next tv -> fr=1, inv=1 in one edge.
- ext_req=1 at fr=3, esyn every 136724 cycles -> locked=1 after the 5th esyn (1 start + 4 good); extsyn=1.
- Locked at fr=3, then stop esyn -> HOLD at counter 136789; lost pulse and extsyn=0 after 3 timeouts.
- Locked, one esyn at period 136724+65 -> ACQ, locked=0, extsyn=0; relock after 4 further good periods.
- Locked at fr=3, commit fr=2 -> state ACQ on the commit edge; esyn every 273448 cycles relocks.
